// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the LEGv8 instruction-fetch stage.
// Holds the address width default, bubble encoding, register-field positions and FSM states.
package fetch_stage_pkg;

    localparam int unsigned ADDR_W_DEF = 64;
    localparam logic [31:0] INSTR_NOP  = 32'h0;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned RD_LSB = 0;
    localparam int unsigned RN_LSB = 5;
    localparam int unsigned RM_LSB = 16;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DRAIN
    } fetchState_e;

    function automatic logic [REG_W-1:0] regField(input logic [31:0] instr, input int unsigned lsb);
        return instr[lsb +: REG_W];
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
interface fetch_stage_if
    import fetch_stage_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: write-enabled load, flush to bubble, async active-low reset.
module ifid_reg
    import fetch_stage_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              writeEn,
    input  logic              flush,
    input  logic              dValid,
    input  logic [ADDR_W-1:0] dPc,
    input  logic [31:0]       dInstr,
    output logic              valid,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       instr
);

    // Flush overrides the write enable so a redirect always kills the slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= INSTR_NOP;
        end else if (flush) begin
            valid <= 1'b0;
            instr <= INSTR_NOP;
        end else if (writeEn) begin
            valid <= dValid;
            pc    <= dPc;
            instr <= dInstr;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 instruction-fetch stage: owns the PC, keeps one imem request outstanding,
// and feeds the IF/ID register with fetched instructions or bubbles.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned        ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              PC_WriteEn,
    input  logic              IFID_WriteEn,
    input  logic              Branch_taken,
    input  logic [ADDR_W-1:0] Branch_target,
    fetch_stage_if.master     imem,
    output logic              IFID_valid,
    output logic [ADDR_W-1:0] IFID_pc,
    output logic [31:0]       IFID_instr,
    output logic [4:0]        IFID_rd,
    output logic [4:0]        IFID_rn,
    output logic [4:0]        IFID_rm
);

    fetchState_e       state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] drainAddr;
    logic [ADDR_W-1:0] pcPlus4;
    logic [31:0]       holdBuf;
    logic              reqQ;
    logic [ADDR_W-1:0] addrQ;
    logic              accept;
    logic              deliver;
    logic [31:0]       ifidInstrD;

    assign accept  = PC_WriteEn & IFID_WriteEn;
    assign pcPlus4 = pc + ADDR_W'(4);

    always_comb begin
        deliver    = 1'b0;
        ifidInstrD = INSTR_NOP;
        if (!Branch_taken && accept) begin
            if (state == FETCH && imem.imem_ack) begin
                deliver    = 1'b1;
                ifidInstrD = imem.imem_rdata;
            end else if (state == HOLD) begin
                deliver    = 1'b1;
                ifidInstrD = holdBuf;
            end
        end
    end

    // imem_req/imem_addr are registered alongside the state so the request
    // address is a flop output and cannot glitch while a request is pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            drainAddr <= '0;
            holdBuf   <= INSTR_NOP;
            reqQ      <= 1'b1;
            addrQ     <= RESET_PC;
        end else if (Branch_taken) begin
            pc      <= Branch_target;
            holdBuf <= INSTR_NOP;
            reqQ    <= 1'b1;
            if (state == FETCH && !imem.imem_ack) begin
                state     <= DRAIN;
                drainAddr <= pc;
                addrQ     <= pc;
            end else if (state == DRAIN) begin
                state <= DRAIN;
                addrQ <= drainAddr;
            end else begin
                state <= FETCH;
                addrQ <= Branch_target;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (imem.imem_ack) begin
                        if (accept) begin
                            pc    <= pcPlus4;
                            addrQ <= pcPlus4;
                        end else begin
                            holdBuf <= imem.imem_rdata;
                            state   <= HOLD;
                            reqQ    <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (accept) begin
                        pc    <= pcPlus4;
                        state <= FETCH;
                        reqQ  <= 1'b1;
                        addrQ <= pcPlus4;
                    end
                end
                DRAIN: begin
                    if (imem.imem_ack) begin
                        state <= FETCH;
                        addrQ <= pc;
                    end
                end
                default: begin
                    state <= FETCH;
                    reqQ  <= 1'b1;
                    addrQ <= pc;
                end
            endcase
        end
    end

    assign imem.imem_req  = reqQ;
    assign imem.imem_addr = addrQ;

    ifid_reg #(
        .ADDR_W (ADDR_W)
    ) u_ifid (
        .clk     (clk),
        .rst_n   (rst_n),
        .writeEn (IFID_WriteEn),
        .flush   (Branch_taken),
        .dValid  (deliver),
        .dPc     (pc),
        .dInstr  (ifidInstrD),
        .valid   (IFID_valid),
        .pc      (IFID_pc),
        .instr   (IFID_instr)
    );

    assign IFID_rd = regField(IFID_instr, RD_LSB);
    assign IFID_rn = regField(IFID_instr, RN_LSB);
    assign IFID_rm = regField(IFID_instr, RM_LSB);

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage with an in-bench behavioural model and memory,
// plus directed scenarios with hand-computed expectations.
module tb_fetch_stage;

    localparam int unsigned    AW  = 64;
    localparam logic [AW-1:0]  RPC = '0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          PC_WriteEn, IFID_WriteEn, Branch_taken;
    logic [AW-1:0] Branch_target;
    logic          IFID_valid;
    logic [AW-1:0] IFID_pc;
    logic [31:0]   IFID_instr;
    logic [4:0]    IFID_rd, IFID_rn, IFID_rm;

    fetch_stage_if #(.ADDR_W(AW)) bus ();

    fetch_stage #(.ADDR_W(AW), .RESET_PC(RPC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .PC_WriteEn    (PC_WriteEn),
        .IFID_WriteEn  (IFID_WriteEn),
        .Branch_taken  (Branch_taken),
        .Branch_target (Branch_target),
        .imem          (bus),
        .IFID_valid    (IFID_valid),
        .IFID_pc       (IFID_pc),
        .IFID_instr    (IFID_instr),
        .IFID_rd       (IFID_rd),
        .IFID_rn       (IFID_rn),
        .IFID_rm       (IFID_rm)
    );

    always #5 clk = ~clk;

    int nVec = 0;
    int nErr = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 = fetching, 1 = holding a stalled word, 2 = draining.
    int            mMode;
    logic [AW-1:0] mPc, mDrain;
    logic [31:0]   mHold;
    logic          eValid;
    logic [AW-1:0] ePc;
    logic [31:0]   eInstr;
    bit            chkOn = 1'b0;

    int unsigned waitCnt, curLat, fixLat = 0;
    bit          randLat = 1'b0;

    task automatic modelReset();
        mMode = 0; mPc = RPC; mDrain = '0; mHold = '0;
        eValid = 1'b0; ePc = '0; eInstr = '0;
        waitCnt = 0; curLat = fixLat;
    endtask

    task automatic bubbleIf(input bit en);
        if (en) begin eValid = 1'b0; eInstr = '0; end
    endtask

    task automatic modelStep(input bit pwe, input bit iwe, input bit br, input logic [AW-1:0] tgt,
                             input bit ack, input logic [31:0] data);
        bit acc;
        acc = pwe && iwe;
        if (br) begin
            eValid = 1'b0; eInstr = '0;
            if (mMode == 0 && !ack) begin mDrain = mPc; mMode = 2; end
            else if (mMode != 2) mMode = 0;
            mPc = tgt;
        end else if (mMode == 0) begin
            if (ack && acc) begin
                eValid = 1'b1; ePc = mPc; eInstr = data; mPc = mPc + 4;
            end else if (ack) begin
                mHold = data; mMode = 1; bubbleIf(iwe);
            end else bubbleIf(iwe);
        end else if (mMode == 1) begin
            if (acc) begin
                eValid = 1'b1; ePc = mPc; eInstr = mHold; mPc = mPc + 4; mMode = 0;
            end else bubbleIf(iwe);
        end else begin
            if (ack) mMode = 0;
            bubbleIf(iwe);
        end
    endtask

    always @(negedge clk) begin
        if (chkOn && rst_n) begin
            chk("req",   bus.imem_req, 64'(mMode != 1));
            chk("addr",  bus.imem_addr, (mMode == 2) ? mDrain : mPc);
            chk("valid", IFID_valid, eValid);
            chk("instr", IFID_instr, eInstr);
            chk("rd",    IFID_rd, eInstr[4:0]);
            chk("rn",    IFID_rn, eInstr[9:5]);
            chk("rm",    IFID_rm, eInstr[20:16]);
            if (eValid) chk("pc", IFID_pc, ePc);
        end
    end

    // Memory returns the low address bits as the instruction word.
    task automatic cycle(input bit pwe, input bit iwe, input bit br, input logic [AW-1:0] tgt);
        logic        ack;
        logic [31:0] data;
        @(negedge clk); #1;
        PC_WriteEn = pwe; IFID_WriteEn = iwe; Branch_taken = br; Branch_target = tgt;
        ack  = bus.imem_req && (waitCnt >= curLat);
        data = ack ? bus.imem_addr[31:0] : $urandom;
        bus.imem_ack = ack; bus.imem_rdata = data;
        modelStep(pwe, iwe, br, tgt, ack, data);
        if (bus.imem_req && ack) begin
            waitCnt = 0;
            curLat  = randLat ? $urandom_range(0, 3) : fixLat;
        end else if (bus.imem_req) begin
            waitCnt++;
        end
        @(posedge clk); #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0; chkOn = 1'b0;
        PC_WriteEn = 1'b1; IFID_WriteEn = 1'b1; Branch_taken = 1'b0; Branch_target = '0;
        bus.imem_ack = 1'b0; bus.imem_rdata = '0;
        modelReset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; chkOn = 1'b1;
    endtask

    initial begin
        doReset();
        chk("rst_req", bus.imem_req, 1);
        chk("rst_addr", bus.imem_addr, RPC);
        chk("rst_valid", IFID_valid, 0);
        chk("rst_instr", IFID_instr, 0);

        // zero-wait stream, then a two-cycle stall with the ack at PC=8
        cycle(1, 1, 0, 0); chk("zw_pc0", IFID_pc, 0); chk("zw_v0", IFID_valid, 1);
        cycle(1, 1, 0, 0); chk("zw_pc4", IFID_pc, 4);
        cycle(0, 0, 0, 0); chk("st_pc", IFID_pc, 4); chk("st_req", bus.imem_req, 0);
        cycle(0, 0, 0, 0); chk("st_pc2", IFID_pc, 4); chk("st_req2", bus.imem_req, 0);
        cycle(1, 1, 0, 0); chk("rel_pc", IFID_pc, 8); chk("rel_addr", bus.imem_addr, 12);
        fixLat = 3;
        cycle(1, 1, 0, 0); chk("rel_instr", IFID_instr, 12); chk("rel_rd", IFID_rd, 12);

        // three-cycle memory latency
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 0, 0);
            chk("lat_addr", bus.imem_addr, 16);
            chk("lat_valid", IFID_valid, 0);
        end
        cycle(1, 1, 0, 0); chk("lat_pc", IFID_pc, 16); chk("lat_v", IFID_valid, 1);

        // redirect while request to 0x14 is pending -> drain
        cycle(1, 1, 1, 64'h100); chk("dr_valid", IFID_valid, 0); chk("dr_addr", bus.imem_addr, 64'h14);
        cycle(1, 1, 0, 0); chk("dr_addr2", bus.imem_addr, 64'h14);
        cycle(1, 1, 0, 0); chk("dr_addr3", bus.imem_addr, 64'h14);
        fixLat = 0;
        cycle(1, 1, 0, 0); chk("dr_tgt", bus.imem_addr, 64'h100); chk("dr_drop", IFID_valid, 0);
        cycle(1, 1, 0, 0); chk("dr_pc", IFID_pc, 64'h100);

        // redirect coinciding with stall and ack
        cycle(0, 0, 1, 64'h200); chk("bs_valid", IFID_valid, 0); chk("bs_addr", bus.imem_addr, 64'h200);
        cycle(1, 1, 0, 0); chk("bs_pc", IFID_pc, 64'h200); chk("bs_instr", IFID_instr, 64'h200);

        // PC wrap and unaligned target
        cycle(1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC);
        cycle(1, 1, 0, 0); chk("wr_pc", IFID_pc, 64'hFFFF_FFFF_FFFF_FFFC); chk("wr_addr", bus.imem_addr, 0);
        cycle(1, 1, 0, 0); chk("wr_pc0", IFID_pc, 0);
        cycle(1, 1, 1, 64'h102);
        cycle(1, 1, 0, 0); chk("ua_pc", IFID_pc, 64'h102);
        cycle(1, 1, 0, 0); chk("ua_pc2", IFID_pc, 64'h106); chk("ua_rn", IFID_rn, 8); chk("ua_rd", IFID_rd, 6);

        // asynchronous reset while a slow request to 0x40 is pending
        cycle(1, 1, 1, 64'h3C);
        fixLat = 5;
        cycle(1, 1, 0, 0);
        cycle(0, 0, 0, 0); chk("ar_addr", bus.imem_addr, 64'h40); chk("ar_pc", IFID_pc, 64'h3C);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", IFID_valid, 0); chk("ar_pcz", IFID_pc, 0); chk("ar_instr", IFID_instr, 0);
        chk("ar_req", bus.imem_req, 1); chk("ar_raddr", bus.imem_addr, RPC);
        fixLat = 0;
        doReset();
        cycle(1, 1, 0, 0); chk("ar_restart", IFID_pc, RPC); chk("ar_rv", IFID_valid, 1);

        // randomized traffic
        randLat = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 9) == 0, {$urandom, $urandom});
            if ($urandom_range(0, 999) == 0) doReset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
